// File: rtl/alu_exec_unit.sv
// Execution responder: accepts one opcode/operand/tag per valid/ready handshake,
// computes single-cycle ops immediately and MUL by a 32-step shift-add.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_op_code,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic [2:0]  dest,
  output logic [31:0] y,
  output logic        y_valid,
  output logic [2:0]  y_dest,
  output logic        zero,
  output logic        carry,
  output logic        overflow,
  output logic        err,
  output logic [1:0]  dbg_state
);

  // Handshake: an op is taken on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE outside reset, and y_valid is a one-cycle strobe.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  state_t      state_q;
  logic [31:0] mcand_q, mplier_q, acc_q;
  logic [4:0]  cnt_q;
  logic [2:0]  tag_q;
  logic [31:0] y_q;
  logic [2:0]  y_dest_q;
  logic        y_valid_q, zero_q, carry_q, overflow_q, err_q;

  logic [32:0] sum_d, diff_d;
  logic [31:0] res_d, acc_d;
  logic        carry_d, overflow_d, err_d;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign y_dest    = y_dest_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  assign sum_d  = {1'b0, data_a} + {1'b0, data_b};
  assign diff_d = {1'b0, data_a} - {1'b0, data_b};
  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

  always_comb begin
    res_d      = y_q;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    err_d      = 1'b0;
    case (alu_op_code)
      OP_ADD: begin
        res_d      = sum_d[31:0];
        carry_d    = sum_d[32];
        overflow_d = (data_a[31] == data_b[31]) && (sum_d[31] != data_a[31]);
      end
      OP_SUB: begin
        res_d      = diff_d[31:0];
        carry_d    = diff_d[32];
        overflow_d = (data_a[31] != data_b[31]) && (diff_d[31] != data_a[31]);
      end
      OP_AND:  res_d = data_a & data_b;
      OP_OR:   res_d = data_a | data_b;
      OP_XOR:  res_d = data_a ^ data_b;
      OP_SLL:  res_d = data_a << data_b[4:0];
      // Reserved opcode keeps the previous result and only raises err.
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mcand_q    <= 32'd0;
      mplier_q   <= 32'd0;
      acc_q      <= 32'd0;
      cnt_q      <= 5'd0;
      tag_q      <= 3'd0;
      y_q        <= 32'd0;
      y_dest_q   <= 3'd0;
      y_valid_q  <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (alu_op_code == OP_MUL) begin
              mcand_q  <= data_a;
              mplier_q <= data_b;
              acc_q    <= 32'd0;
              cnt_q    <= 5'd0;
              tag_q    <= dest;
              state_q  <= S_MUL;
            end else begin
              y_q        <= res_d;
              zero_q     <= !err_d && (res_d == 32'd0);
              carry_q    <= carry_d;
              overflow_q <= overflow_d;
              err_q      <= err_d;
              y_dest_q   <= dest;
              y_valid_q  <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            y_q        <= acc_d;
            zero_q     <= (acc_d == 32'd0);
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
            y_dest_q   <= tag_q;
            y_valid_q  <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution-side responder for the register-file controller: it accepts one operation (3-bit opcode, two 32-bit operands, 3-bit destination tag) per valid/ready handshake and computes it. Single-cycle ops complete in one cycle; MUL runs a 32-step shift-add. It returns the 32-bit result `y` with a one-cycle `y_valid` strobe, flags and the echoed destination tag, so the controller can write `y` back into its register file.

## Interface
- No parameters; data width fixed at 32, opcode 3, tag 3.
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operation request from controller
- `in_ready`  out  1  unit can accept; equals (state==IDLE) && !rst
- `alu_op_code`  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 MUL, 111 reserved
- `data_a`, `data_b`  in  32  operands, sampled only at accept
- `dest`  in  3  destination register tag, sampled at accept
- `y`  out  32  result, registered
- `y_valid`  out  1  one-cycle strobe, `y`/flags/`y_dest` valid
- `y_dest`  out  3  echoed `dest` of completed op
- `zero`, `carry`, `overflow`, `err`  out  1 each  result flags, registered with `y`

## Operation
- Accept = `in_valid && in_ready` at a rising edge; operands, opcode and dest are latched then; inputs ignored otherwise.
- States: IDLE, MUL, DONE.
  - IDLE: accept of non-MUL op → compute, register outputs, go DONE. Accept of MUL → load multiplicand=`data_a`, multiplier=`data_b`, acc=0, cnt=0, go MUL. No accept → stay.
  - MUL: each edge: if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++. On the edge that processes step 31 (cnt==31), write `y`=acc result, go DONE.
  - DONE: `y_valid`=1 for this cycle only; next edge → IDLE unconditionally.
- Arithmetic (all modulo 2^32):
  - ADD: y=a+b; carry=bit 32 of 33-bit sum; overflow=signed overflow.
  - SUB: y=a−b; carry=1 iff a<b unsigned (borrow); overflow=signed overflow.
  - AND/OR/XOR: bitwise; carry=overflow=0.
  - SLL: y=a<<b[4:0]; b[31:5] ignored; carry=overflow=0.
  - MUL: y=low 32 bits of a×b (unsigned); carry=overflow=0.
  - zero=(y==0) for all legal ops.
- Reserved opcode 111: completes in one cycle like a logic op; err=1, `y` holds its previous value, zero/carry/overflow=0. `err`=0 for every legal op.
- `y`, flags and `y_dest` hold their values after `y_valid` drops, until the next completion.

## Timing
- Reset (async assert, sync release): state=IDLE, `y`=0, `y_valid`=0, `y_dest`=0, all flags 0, cnt=0; `in_ready`=0 while `rst` high.
- Non-MUL/reserved: accepted at edge N → `y_valid` high in cycle N..N+1, `in_ready` low that cycle, high again after edge N+1. Throughput one op per 2 cycles.
- MUL: accepted at edge N → `y_valid` high after edge N+32 for one cycle; `in_ready` low from N through N+33.
- `in_valid` held high through busy cycles: no second accept; the request is taken at the first edge with `in_ready`=1 (the edge leaving DONE is not an accept edge).
- `rst` asserted mid-MUL or in DONE: immediate abort, no `y_valid` issued, outputs to reset values.
- No combinational path from inputs to outputs other than `rst`→`in_ready`.

## Test plan
- Reset: assert `rst` during MUL step 10 → `y_valid` never pulses, `y`=0, `in_ready`=0 until release, then 1.
- ADD a=0xFFFF_FFFF, b=1, dest=3 → next cycle `y`=0, zero=1, carry=1, overflow=0, `y_dest`=3, `y_valid` one cycle; ADD 0x7FFF_FFFF+1 → y=0x8000_0000, overflow=1, carry=0.
- SUB a=5, b=7 → y=0xFFFF_FFFE, carry=1, zero=0; SLL a=1, b=0x23 → y=0x0000_0008.
- MUL a=0x0001_0000, b=0x0003_0001 → y=0x0001_0000 (wrapped), `y_valid` exactly 32 edges after accept; MUL 1234×5678 → y=7006652.
- Opcode 111 after an ADD yielding 0x10 → err=1, y stays 0x10, flags 0, `y_valid` one cycle.
- Back-to-back: `in_valid` held high with AND, OR queued → accepts spaced 2 cycles apart; during MUL, `in_ready`=0 for 33 cycles and no input change affects `y`.
